// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, requests one word per instruction from the I-cache, hands it to decode.
// Latency: an ack in cycle N presents the instruction after edge N; L-cycle ack latency gives L+1 cycles/instr.
// Backpressure: Stall_fmem or Want_Freeze_IN hold the presented instruction; no new request until it is consumed.
//
// Ports:
//   CLK, RESET                         clock, async active-low reset
//   Alt_PC_IN / Request_Alt_PC_IN      redirect target and request from decode (sampled on consume edges only)
//   Want_Freeze_IN                     re-present the current instruction instead of advancing
//   Stall_fmem                         data-cache stall, decode is not advancing
//   IC_Req_OUT / IC_Addr_OUT           instruction-cache read request, word aligned
//   IC_Ack_IN / IC_Data_IN             cache response (may come in the request cycle)
//   Instr1_OUT, Instr_PC_OUT,
//   Instr_PC_Plus4_OUT                 instruction to decode with its PC and PC+4
//   ReadyfID_OUT                       high when no instruction is available (active-high not-ready)
module instr_fetch_unit #(
    parameter logic [31:0] BOOT_PC = 32'h0040_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Alt_PC_IN,
    input  logic        Request_Alt_PC_IN,
    input  logic        Want_Freeze_IN,
    input  logic        Stall_fmem,
    output logic        IC_Req_OUT,
    output logic [31:0] IC_Addr_OUT,
    input  logic        IC_Ack_IN,
    input  logic [31:0] IC_Data_IN,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
    output logic        ReadyfID_OUT
);

    typedef enum logic {
        S_WAIT  = 1'b0,
        S_VALID = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] instr, instr_nxt;
    logic [31:0] instr_pc, instr_pc_nxt;
    logic        consume;

    // One decode advance: an instruction is on offer and the data cache is not stalling.
    assign consume = (state == S_VALID) && !Stall_fmem;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_WAIT;
            fetch_pc <= BOOT_PC;
            instr    <= 32'h0000_0000;
            instr_pc <= 32'h0000_0000;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            instr    <= instr_nxt;
            instr_pc <= instr_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        instr_nxt    = instr;
        instr_pc_nxt = instr_pc;
        case (state)
            S_WAIT: begin
                // Stall_fmem does not matter here: the response is captured regardless.
                if (IC_Ack_IN) begin
                    instr_nxt    = IC_Data_IN;
                    instr_pc_nxt = fetch_pc;
                    state_nxt    = S_VALID;
                end
            end
            S_VALID: begin
                // The redirect raised with the branch is only seen on the next consume,
                // i.e. when the delay slot leaves, so the delay slot is never squashed.
                // A freeze on a consume edge re-presents the instruction and drops the redirect;
                // decode re-raises it when it re-evaluates. Acks arriving here are ignored.
                if (consume && !Want_Freeze_IN) begin
                    fetch_pc_nxt = Request_Alt_PC_IN ? Alt_PC_IN : (instr_pc + 32'd4);
                    state_nxt    = S_WAIT;
                end
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    assign IC_Req_OUT         = (state == S_WAIT);
    assign ReadyfID_OUT       = (state == S_WAIT);
    assign IC_Addr_OUT        = {fetch_pc[31:2], 2'b00};
    assign Instr1_OUT         = instr;
    assign Instr_PC_OUT       = {instr_pc[31:2], 2'b00};
    assign Instr_PC_Plus4_OUT = {instr_pc[31:2], 2'b00} + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, reset corner sequence, then randomized run vs model.
// Latency: inputs driven and outputs sampled on the falling edge, one row per clock.
// Backpressure: stall/freeze/redirect patterns come from the table and from $urandom.
module tb_instr_fetch_unit;

    localparam logic [31:0] BOOT = 32'h0040_0000;

    logic        CLK;
    logic        RESET;
    logic [31:0] Alt_PC_IN;
    logic        Request_Alt_PC_IN;
    logic        Want_Freeze_IN;
    logic        Stall_fmem;
    logic        IC_Req_OUT;
    logic [31:0] IC_Addr_OUT;
    logic        IC_Ack_IN;
    logic [31:0] IC_Data_IN;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;
    logic        ReadyfID_OUT;

    instr_fetch_unit #(.BOOT_PC(BOOT)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Alt_PC_IN         (Alt_PC_IN),
        .Request_Alt_PC_IN (Request_Alt_PC_IN),
        .Want_Freeze_IN    (Want_Freeze_IN),
        .Stall_fmem        (Stall_fmem),
        .IC_Req_OUT        (IC_Req_OUT),
        .IC_Addr_OUT       (IC_Addr_OUT),
        .IC_Ack_IN         (IC_Ack_IN),
        .IC_Data_IN        (IC_Data_IN),
        .Instr1_OUT        (Instr1_OUT),
        .Instr_PC_OUT      (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT),
        .ReadyfID_OUT      (ReadyfID_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Each row: inputs held across the following rising edge, and the outputs
    // required during that same cycle (before the edge).
    typedef struct {
        logic        st;
        logic        fz;
        logic        ar;
        logic [31:0] alt;
        logic        ak;
        logic [31:0] dat;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic st, input logic fz, input logic ar, input logic [31:0] alt,
                     input logic ak, input logic [31:0] dat, input logic e_req,
                     input logic [31:0] e_addr, input logic [31:0] e_instr, input logic [31:0] e_pc);
        vec_t r;
        r.st = st; r.fz = fz; r.ar = ar; r.alt = alt; r.ak = ak; r.dat = dat;
        r.e_req = e_req; r.e_addr = e_addr; r.e_instr = e_instr; r.e_pc = e_pc;
        vecs.push_back(r);
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic [31:0] e_instr, input logic [31:0] e_pc);
        logic [31:0] pc_al;
        pc_al = {e_pc[31:2], 2'b00};
        chk({tag, " req"},   {31'd0, IC_Req_OUT},   {31'd0, e_req});
        chk({tag, " rdy"},   {31'd0, ReadyfID_OUT}, {31'd0, e_req});
        if (e_req) chk({tag, " addr"}, IC_Addr_OUT, {e_addr[31:2], 2'b00});
        chk({tag, " instr"}, Instr1_OUT, e_instr);
        chk({tag, " pc"},    Instr_PC_OUT, pc_al);
        chk({tag, " pc4"},   Instr_PC_Plus4_OUT, pc_al + 32'd4);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2400_0000;
    endfunction

    // Behavioural model of the fetch stage: "is an instruction on offer",
    // the address being fetched, and the offered instruction with its PC.
    logic        m_has;
    logic [31:0] m_fetch, m_instr, m_pc;

    initial begin
        RESET = 1'b0; Alt_PC_IN = '0; Request_Alt_PC_IN = 1'b0; Want_Freeze_IN = 1'b0;
        Stall_fmem = 1'b0; IC_Ack_IN = 1'b0; IC_Data_IN = '0;

        // ---- reset state ----
        #12;
        check_outputs("reset", 1'b1, BOOT, 32'h0, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("reset addr after release", IC_Addr_OUT, BOOT);

        // ---- directed table ----
        v(0,0,0,32'h0,        1,32'h2408_0001, 1,32'h0040_0000, 32'h0,          32'h0);
        v(0,0,0,32'h0,        0,32'h0,         0,32'h0,         32'h2408_0001, 32'h0040_0000);
        v(0,0,0,32'h0,        1,32'h2408_0002, 1,32'h0040_0004, 32'h2408_0001, 32'h0040_0000);
        v(0,0,0,32'h0,        0,32'h0,         0,32'h0,         32'h2408_0002, 32'h0040_0004);
        v(0,0,0,32'h0,        1,32'h2408_0003, 1,32'h0040_0008, 32'h2408_0002, 32'h0040_0004);
        v(0,0,0,32'h0,        0,32'h0,         0,32'h0,         32'h2408_0003, 32'h0040_0008);
        v(0,0,0,32'h0,        1,32'h2408_0004, 1,32'h0040_000C, 32'h2408_0003, 32'h0040_0008);
        v(0,0,0,32'h0,        0,32'h0,         0,32'h0,         32'h2408_0004, 32'h0040_000C);
        v(0,0,0,32'h0,        1,32'h1000_003F, 1,32'h0040_0010, 32'h2408_0004, 32'h0040_000C);
        // branch consumed; decode raises the redirect afterwards
        v(0,0,0,32'h0,        0,32'h0,         0,32'h0,         32'h1000_003F, 32'h0040_0010);
        v(0,0,1,32'h0040_0100,1,32'h2409_0005, 1,32'h0040_0014, 32'h1000_003F, 32'h0040_0010);
        v(0,0,1,32'h0040_0100,0,32'h0,         0,32'h0,         32'h2409_0005, 32'h0040_0014);
        v(0,0,0,32'h0,        1,32'h0000_000C, 1,32'h0040_0100, 32'h2409_0005, 32'h0040_0014);
        // syscall frozen for four consume edges; redirect on the last is dropped
        v(0,1,0,32'h0,        0,32'h0,         0,32'h0,         32'h0000_000C, 32'h0040_0100);
        v(0,1,0,32'h0,        0,32'h0,         0,32'h0,         32'h0000_000C, 32'h0040_0100);
        v(0,1,0,32'h0,        0,32'h0,         0,32'h0,         32'h0000_000C, 32'h0040_0100);
        v(0,1,1,32'h1234_5678,0,32'h0,         0,32'h0,         32'h0000_000C, 32'h0040_0100);
        v(0,0,0,32'h0,        0,32'h0,         0,32'h0,         32'h0000_000C, 32'h0040_0100);
        v(0,0,0,32'h0,        1,32'h2408_0007, 1,32'h0040_0104, 32'h0000_000C, 32'h0040_0100);
        // stall in VALID with redirect pending; stray ack ignored
        v(1,0,1,32'h0040_0200,1,32'hDEAD_BEEF, 0,32'h0,         32'h2408_0007, 32'h0040_0104);
        v(1,0,1,32'h0040_0200,0,32'h0,         0,32'h0,         32'h2408_0007, 32'h0040_0104);
        v(1,0,1,32'h0040_0200,0,32'h0,         0,32'h0,         32'h2408_0007, 32'h0040_0104);
        v(0,0,1,32'h0040_0200,0,32'h0,         0,32'h0,         32'h2408_0007, 32'h0040_0104);
        // ack latency 3 with stall toggling in WAIT
        v(1,0,0,32'h0,        0,32'h0,         1,32'h0040_0200, 32'h2408_0007, 32'h0040_0104);
        v(0,0,0,32'h0,        0,32'h0,         1,32'h0040_0200, 32'h2408_0007, 32'h0040_0104);
        v(1,0,0,32'h0,        1,32'h2408_0008, 1,32'h0040_0200, 32'h2408_0007, 32'h0040_0104);
        // redirect to the top word, then wrap
        v(0,0,1,32'hFFFF_FFFC,0,32'h0,         0,32'h0,         32'h2408_0008, 32'h0040_0200);
        v(0,0,0,32'h0,        1,32'h2408_0009, 1,32'hFFFF_FFFC, 32'h2408_0008, 32'h0040_0200);
        v(0,0,0,32'h0,        0,32'h0,         0,32'h0,         32'h2408_0009, 32'hFFFF_FFFC);
        v(0,0,0,32'h0,        0,32'h0,         1,32'h0000_0000, 32'h2408_0009, 32'hFFFF_FFFC);

        foreach (vecs[i]) begin
            @(negedge CLK);
            Stall_fmem = vecs[i].st; Want_Freeze_IN = vecs[i].fz;
            Request_Alt_PC_IN = vecs[i].ar; Alt_PC_IN = vecs[i].alt;
            IC_Ack_IN = vecs[i].ak; IC_Data_IN = vecs[i].dat;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                          vecs[i].e_instr, vecs[i].e_pc);
        end

        // ---- reset pulsed mid-WAIT, with a response in flight ----
        @(negedge CLK);
        Stall_fmem = 1'b0; Want_Freeze_IN = 1'b0; Request_Alt_PC_IN = 1'b0;
        IC_Ack_IN = 1'b1; IC_Data_IN = 32'h1111_2222;
        #2 RESET = 1'b0;
        #1;
        check_outputs("async reset", 1'b1, BOOT, 32'h0, 32'h0);
        @(negedge CLK);
        IC_Ack_IN = 1'b0;
        RESET = 1'b1;
        #1;
        check_outputs("after reset", 1'b1, BOOT, 32'h0, 32'h0);

        // ---- randomized run against the model ----
        m_has = 1'b0; m_fetch = BOOT; m_instr = 32'h0; m_pc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            check_outputs("rand", !m_has, m_fetch, m_instr, m_pc);
            Stall_fmem        = ($urandom_range(0, 3) == 0);
            Want_Freeze_IN    = ($urandom_range(0, 4) == 0);
            Request_Alt_PC_IN = ($urandom_range(0, 3) == 0);
            Alt_PC_IN         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom();
            IC_Ack_IN         = ($urandom_range(0, 2) == 0);
            IC_Data_IN        = IC_Req_OUT ? mem_word(IC_Addr_OUT) : $urandom();
            // what the coming edge must do
            if (!m_has) begin
                if (IC_Ack_IN) begin
                    m_instr = mem_word({m_fetch[31:2], 2'b00});
                    m_pc    = m_fetch;
                    m_has   = 1'b1;
                end
            end else if (!Stall_fmem && !Want_Freeze_IN) begin
                m_fetch = Request_Alt_PC_IN ? Alt_PC_IN : m_pc + 32'd4;
                m_has   = 1'b0;
            end
        end

        @(negedge CLK);
        check_outputs("final", !m_has, m_fetch, m_instr, m_pc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
